// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO: default parameter values,
// depth derivation, parameter legality rules and the per-cycle operation code.
package fifo_pkg;

    localparam int DEF_ADDRESS    = 3;
    localparam int DEF_DATA       = 8;
    localparam int DEF_AFULL_LVL  = 6;
    localparam int DEF_AEMPTY_LVL = 1;
    localparam int DEF_FWFT       = 0;

    // What the FIFO actually does on a given edge, after full/empty gating.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    function automatic int depth_of(input int address);
        return 1 << address;
    endfunction

    // Thresholds must sit strictly inside the occupancy range and be ordered.
    function automatic bit params_legal(input int address, input int aempty_lvl,
                                        input int afull_lvl);
        return (address >= 1) && (aempty_lvl >= 1) && (aempty_lvl < afull_lvl) &&
               (afull_lvl <= depth_of(address) - 1);
    endfunction

    function automatic fifo_op_e classify_op(input logic write_ok, input logic read_ok);
        return fifo_op_e'({write_ok, read_ok});
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous
// read port, no reset so it maps onto distributed RAM.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int address = DEF_ADDRESS,
    parameter int data    = DEF_DATA
) (
    input  logic               clk,
    input  logic               write_en,
    input  logic [address-1:0] write_addr,
    input  logic [data-1:0]    write_data,
    input  logic [address-1:0] read_addr,
    output logic [data-1:0]    read_data
);

    logic [data-1:0] mem [0:depth_of(address)-1];

    // Store the incoming word on an accepted write; contents are never cleared.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO control: wrap-bit pointers, occupancy counter, threshold
// flags, overflow/underflow pulses and registered or fall-through read data.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int address    = DEF_ADDRESS,
    parameter int data       = DEF_DATA,
    parameter int afull_lvl  = DEF_AFULL_LVL,
    parameter int aempty_lvl = DEF_AEMPTY_LVL,
    parameter int fwft       = DEF_FWFT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [data-1:0]  write_data,
    input  logic             write_inc,
    input  logic             read_inc,
    output logic [data-1:0]  read_data,
    output logic             read_empty,
    output logic             write_full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [address:0] count,
    output logic             overflow,
    output logic             underflow
);

    typedef logic [address:0] ptr_t;

    localparam ptr_t ONE        = ptr_t'(1);
    localparam ptr_t AFULL_CNT  = ptr_t'(afull_lvl);
    localparam ptr_t AEMPTY_CNT = ptr_t'(aempty_lvl);

    generate
        if (!params_legal(address, aempty_lvl, afull_lvl)) begin : g_param_check
            $error("sync_fifo_flags: thresholds must satisfy 1 <= aempty_lvl < afull_lvl <= DEPTH-1");
        end
    endgenerate

    ptr_t            write_ptr;
    ptr_t            read_ptr;
    ptr_t            count_q;
    logic            overflow_q;
    logic            underflow_q;
    logic            empty;
    logic            full;
    logic            write_ok;
    logic            read_ok;
    fifo_op_e        op;
    logic [data-1:0] ram_read_data;

    // Extra top bit distinguishes full from empty when the low bits match.
    assign empty = (write_ptr == read_ptr);
    assign full  = (write_ptr[address-1:0] == read_ptr[address-1:0]) &&
                   (write_ptr[address] != read_ptr[address]);

    assign write_ok = write_inc && !full;
    assign read_ok  = read_inc && !empty;
    assign op       = classify_op(write_ok, read_ok);

    // Advance each pointer only on its own accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_ptr <= '0;
            read_ptr  <= '0;
        end else begin
            if (write_ok) begin
                write_ptr <= write_ptr + ONE;
            end
            if (read_ok) begin
                read_ptr <= read_ptr + ONE;
            end
        end
    end

    // Occupancy moves only when exactly one side is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            case (op)
                OP_WRITE: count_q <= count_q + ONE;
                OP_READ:  count_q <= count_q - ONE;
                default:  count_q <= count_q;
            endcase
        end
    end

    // Rejected requests leave a one-cycle pulse behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= write_inc && full;
            underflow_q <= read_inc && empty;
        end
    end

    fifo_ram #(
        .address (address),
        .data    (data)
    ) u_ram (
        .clk        (clk),
        .write_en   (write_ok),
        .write_addr (write_ptr[address-1:0]),
        .write_data (write_data),
        .read_addr  (read_ptr[address-1:0]),
        .read_data  (ram_read_data)
    );

    generate
        if (fwft != 0) begin : g_fwft
            assign read_data = ram_read_data;
        end else begin : g_registered
            logic [data-1:0] read_data_q;

            // Capture the head word as it is popped and hold it until the next pop.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    read_data_q <= '0;
                end else if (read_ok) begin
                    read_data_q <= ram_read_data;
                end
            end

            assign read_data = read_data_q;
        end
    endgenerate

    assign read_empty   = empty;
    assign write_full   = full;
    assign count        = count_q;
    assign almost_full  = (count_q >= AFULL_CNT);
    assign almost_empty = (count_q <= AEMPTY_CNT);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: one registered-read instance and one
// fall-through instance share clock and reset.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] write_data = '0;
    logic       write_inc  = 1'b0;
    logic       read_inc   = 1'b0;
    logic [7:0] read_data;
    logic       read_empty, write_full, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    logic [7:0] f_write_data = '0;
    logic       f_write_inc  = 1'b0;
    logic       f_read_inc   = 1'b0;
    logic [7:0] f_read_data;
    logic       f_read_empty, f_write_full, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [3:0] f_count;

    int checkCount = 0;
    int failCount  = 0;

    sync_fifo_flags #(.address(3), .data(8), .afull_lvl(6), .aempty_lvl(1), .fwft(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .write_data   (write_data),
        .write_inc    (write_inc),
        .read_inc     (read_inc),
        .read_data    (read_data),
        .read_empty   (read_empty),
        .write_full   (write_full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    sync_fifo_flags #(.address(3), .data(8), .afull_lvl(6), .aempty_lvl(1), .fwft(1)) dut_fwft (
        .clk          (clk),
        .rst          (rst),
        .write_data   (f_write_data),
        .write_inc    (f_write_inc),
        .read_inc     (f_read_inc),
        .read_data    (f_read_data),
        .read_empty   (f_read_empty),
        .write_full   (f_write_full),
        .almost_full  (f_almost_full),
        .almost_empty (f_almost_empty),
        .count        (f_count),
        .overflow     (f_overflow),
        .underflow    (f_underflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one set of requests and sample 1 time unit after the next edge.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] d);
        write_inc  = wr;
        read_inc   = rd;
        write_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic applyFwft(input logic wr, input logic rd, input logic [7:0] d);
        f_write_inc  = wr;
        f_read_inc   = rd;
        f_write_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " count"}, 32'(count), 0);
        checkOutput({tag, " empty"}, 32'(read_empty), 1);
        checkOutput({tag, " full"}, 32'(write_full), 0);
        checkOutput({tag, " aempty"}, 32'(almost_empty), 1);
        checkOutput({tag, " afull"}, 32'(almost_full), 0);
        checkOutput({tag, " ovf"}, 32'(overflow), 0);
        checkOutput({tag, " unf"}, 32'(underflow), 0);
        checkOutput({tag, " rdata"}, 32'(read_data), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        checkOutput("fwft reset empty", 32'(f_read_empty), 1);
        #2 rst = 1'b0;

        // Fill with 0x01..0x08
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(i));
            checkOutput("fill count", 32'(count), 32'(i));
            checkOutput("fill afull", 32'(almost_full), (i >= 6) ? 1 : 0);
            checkOutput("fill aempty", 32'(almost_empty), (i <= 1) ? 1 : 0);
            checkOutput("fill full", 32'(write_full), (i == 8) ? 1 : 0);
            checkOutput("fill empty", 32'(read_empty), 0);
        end

        // Write into a full FIFO is rejected
        applyStimulus(1'b1, 1'b0, 8'hFF);
        checkOutput("ovf pulse", 32'(overflow), 1);
        checkOutput("ovf count", 32'(count), 8);
        checkOutput("ovf full", 32'(write_full), 1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("ovf cleared", 32'(overflow), 0);
        checkOutput("ovf count hold", 32'(count), 8);

        // Drain, expecting 0x01..0x08 in order
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00);
            checkOutput("drain data", 32'(read_data), 32'(i));
            checkOutput("drain count", 32'(count), 32'(8 - i));
            checkOutput("drain empty", 32'(read_empty), (i == 8) ? 1 : 0);
            checkOutput("drain full", 32'(write_full), 0);
        end
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("rdata hold", 32'(read_data), 8'h08);

        // Read from empty is rejected
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("unf pulse", 32'(underflow), 1);
        checkOutput("unf empty", 32'(read_empty), 1);
        checkOutput("unf count", 32'(count), 0);
        checkOutput("unf rdata", 32'(read_data), 8'h08);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("unf cleared", 32'(underflow), 0);

        // Steady state at count=4 with simultaneous read and write across wraps
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 8'(8'h10 + i));
        checkOutput("prefill count", 32'(count), 4);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 1'b1, 8'(8'h14 + k));
            checkOutput("both data", 32'(read_data), 32'(8'h10 + k));
            checkOutput("both count", 32'(count), 4);
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b1, 8'h00);
            checkOutput("tail data", 32'(read_data), 32'(8'h24 + k));
        end
        checkOutput("tail empty", 32'(read_empty), 1);

        // Read+write while empty: write wins, read rejected
        applyStimulus(1'b1, 1'b1, 8'h77);
        checkOutput("empty both unf", 32'(underflow), 1);
        checkOutput("empty both count", 32'(count), 1);
        checkOutput("empty both rdata", 32'(read_data), 8'h27);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("empty both pop", 32'(read_data), 8'h77);
        checkOutput("empty both empty", 32'(read_empty), 1);

        // Read+write while full: read wins, write rejected
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 8'(8'h80 + i));
        checkOutput("refill full", 32'(write_full), 1);
        applyStimulus(1'b1, 1'b1, 8'hEE);
        checkOutput("full both ovf", 32'(overflow), 1);
        checkOutput("full both count", 32'(count), 7);
        checkOutput("full both rdata", 32'(read_data), 8'h80);
        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00);
            checkOutput("full both drain", 32'(read_data), 32'(8'h80 + i));
        end
        checkOutput("full both empty", 32'(read_empty), 1);
        applyStimulus(1'b0, 1'b0, 8'h00);

        // Fall-through instance
        applyFwft(1'b1, 1'b0, 8'hA5);
        checkOutput("fwft head", 32'(f_read_data), 8'hA5);
        checkOutput("fwft empty", 32'(f_read_empty), 0);
        applyFwft(1'b0, 1'b0, 8'h00);
        checkOutput("fwft head hold", 32'(f_read_data), 8'hA5);
        applyFwft(1'b0, 1'b1, 8'h00);
        checkOutput("fwft popped empty", 32'(f_read_empty), 1);
        checkOutput("fwft popped count", 32'(f_count), 0);
        applyFwft(1'b1, 1'b0, 8'h11);
        applyFwft(1'b1, 1'b0, 8'h22);
        checkOutput("fwft first", 32'(f_read_data), 8'h11);
        applyFwft(1'b0, 1'b1, 8'h00);
        checkOutput("fwft second", 32'(f_read_data), 8'h22);
        checkOutput("fwft count", 32'(f_count), 1);
        applyFwft(1'b0, 1'b0, 8'h00);

        // Asynchronous reset mid-burst at count=5
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'(8'h30 + i));
        checkOutput("burst count", 32'(count), 5);
        #2 rst = 1'b1;
        #1;
        checkResetState("async reset");
        checkOutput("async reset fwft empty", 32'(f_read_empty), 1);
        applyStimulus(1'b1, 1'b1, 8'h99);
        checkOutput("held reset count", 32'(count), 0);
        checkOutput("held reset empty", 32'(read_empty), 1);
        write_inc = 1'b0;
        read_inc  = 1'b0;
        #2 rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h5A);
        checkOutput("post reset count", 32'(count), 1);
        checkOutput("post reset empty", 32'(read_empty), 0);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("post reset data", 32'(read_data), 8'h5A);
        checkOutput("post reset drained", 32'(read_empty), 1);
        applyStimulus(1'b0, 1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 The block SHALL have parameter: address, default 3, log2 of depth (DEPTH = 2**address entries).
REQ-002 The block SHALL have parameter: data, default 8, word width in bits.
REQ-003 The block SHALL have parameter: afull_lvl, default 6, almost_full asserts when count >= afull_lvl.
REQ-004 The block SHALL have parameter: aempty_lvl, default 1, almost_empty asserts when count <= aempty_lvl.
REQ-005 The block SHALL have parameter: fwft, default 0, 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 The block SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-007 The block SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-008 The block SHALL have port: write_data  input  data  word to enqueue.
REQ-009 The block SHALL have port: write_inc  input  1  write request.
REQ-010 The block SHALL have port: read_inc  input  1  read request.
REQ-011 The block SHALL have port: read_data  output  data  dequeued word.
REQ-012 The block SHALL have port: read_empty  output  1  FIFO holds 0 words.
REQ-013 The block SHALL have port: write_full  output  1  FIFO holds DEPTH words.
REQ-014 The block SHALL have port: almost_full  output  1  threshold flag.
REQ-015 The block SHALL have port: almost_empty  output  1  threshold flag.
REQ-016 The block SHALL have port: count  output  address+1  current occupancy, 0..DEPTH.
REQ-017 The block SHALL have port: overflow  output  1  one-cycle pulse on rejected write.
REQ-018 The block SHALL have port: underflow  output  1  one-cycle pulse on rejected read.

Function
REQ-019 Write SHALL be accepted iff write_inc=1 and write_full=0 at the clock edge; the word is stored at the write pointer, and the pointer increments modulo DEPTH.
REQ-020 Read SHALL be accepted iff read_inc=1 and read_empty=0 at the clock edge; the read pointer increments modulo DEPTH.
REQ-021 Pointers SHALL be address+1 bits (extra wrap bit); empty = pointers equal, full = low bits equal and wrap bits differ.
REQ-022 count SHALL be +1 on write-only, -1 on read-only, unchanged on both or neither; it SHALL never exceed DEPTH or go below 0.
REQ-023 Simultaneous accepted read and write SHALL be legal at any occupancy in 1..DEPTH-1; when full, the write is rejected even if a read is accepted in the same cycle; when empty, the read is rejected even if a write is accepted.
REQ-024 All flags and count SHALL be derived only from registered state (no combinational path from write_inc/read_inc); they update in the cycle after the causing edge.
REQ-025 In fwft=0 mode, read_data SHALL be registered: the word popped at edge N is valid after edge N and held until the next accepted read.
REQ-026 In fwft=1 mode, read_data SHALL present the head word whenever read_empty=0 (no read_inc needed); an accepted read advances to the next word after the edge; the value is don't-care while empty.
REQ-027 A word written into an empty FIFO at edge N SHALL deassert read_empty after edge N (1-cycle write-to-read latency).
REQ-028 overflow SHALL pulse for exactly one cycle after an edge with write_inc=1 and write_full=1; underflow likewise for read_inc=1 and read_empty=1; FIFO state is unchanged by rejected requests.
REQ-029 Pointer wrap SHALL be seamless: data order is preserved across any number of wraps.

Reset
REQ-030 On rst=1, asynchronously: pointers=0, count=0, read_empty=1, write_full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, registered read_data=0.
REQ-031 Storage array contents SHALL NOT be reset; reset mid-operation discards all queued words.
REQ-032 Requests asserted while rst=1 SHALL be ignored; operation resumes on the first rising edge after deassertion.

Structure
REQ-033 Default widths, DEPTH derivation and parameter legality limits (1 <= aempty_lvl < afull_lvl <= DEPTH-1) SHALL live in a shared package fifo_pkg.
REQ-034 Storage SHALL be one sub-module fifo_ram: single-clock, 1 write port, 1 read port, no reset; the control logic stays in sync_fifo_flags.

Verification
REQ-035 Reset, then write 8 words 0x01..0x08 back-to-back -> write_full=1 and count=8 after the 8th edge, almost_full=1 from count=6.
REQ-036 With FIFO full, pulse write_inc with 0xFF -> overflow=1 for one cycle; count stays 8; the subsequent 8 reads return 0x01..0x08 exactly.
REQ-037 From empty, pulse read_inc -> underflow=1 for one cycle; read_empty stays 1; count stays 0.
REQ-038 At count=4, assert write_inc and read_inc together for 20 cycles with an incrementing pattern -> count stays 4; output order matches input across the pointer wraps.
REQ-039 fwft=1: write 0xA5 into empty -> read_data=0xA5 and read_empty=0 after that edge without read_inc; read -> read_empty=1.
REQ-040 Assert rst asynchronously mid-burst at count=5 -> all outputs return to reset values before the next edge; the next write/read pair returns the new word.
